// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter_pkg
//  Brief    : Shared widths, arbiter state encoding and counter helper for the
//             register-file writeback arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

  // Register-file geometry
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  // Width of the requester-1 denial counter
  localparam int CNT_W  = 3;

  // Arbiter state encoding: NORM favours the load unit, STARV favours the ALU
  localparam logic [0:0] NORM  = 1'b0;
  localparam logic [0:0] STARV = 1'b1;

  // Saturating increment so a large STARVE_MAX can never wrap the counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Brief    : Two-requester register-file writeback arbiter. The load unit
//             (requester 0) normally wins; the ALU (requester 1) is promoted
//             after STARVE_MAX consecutive denials. Writes are registered with
//             one cycle of latency; destination 0 is accepted but never
//             written. Optional forwarding compare of the pending write
//             against two read addresses.
//  Config   : RF_WB_ARBITER_FWD_EN - enables the forwarding hit/data outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  // Load-unit writeback
  input  logic              REQ0_V,
  input  logic [REG_AW-1:0] REQ0_A,
  input  logic [XLEN-1:0]   REQ0_D,
  output logic              REQ0_R,
  // ALU writeback
  input  logic              REQ1_V,
  input  logic [REG_AW-1:0] REQ1_A,
  input  logic [XLEN-1:0]   REQ1_D,
  output logic              REQ1_R,
  // Register-file write port
  output logic              WE,
  output logic [REG_AW-1:0] A3,
  output logic [XLEN-1:0]   WD3,
  // Forwarding
  input  logic [REG_AW-1:0] RA1,
  input  logic [REG_AW-1:0] RA2,
  output logic              FWD1_HIT,
  output logic              FWD2_HIT,
  output logic [XLEN-1:0]   FWD_D
);

  // Threshold clipped to what the counter can represent
  localparam int              C_LIM_INT   = (STARVE_MAX > 7) ? 7 :
                                            ((STARVE_MAX < 0) ? 0 : STARVE_MAX);
  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(C_LIM_INT);

  logic              w_gnt0;
  logic              w_gnt1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              we_q,    we_d;
  logic [REG_AW-1:0] a3_q,    a3_d;
  logic [XLEN-1:0]   wd3_q,   wd3_d;

  // Grant: requester 1 wins when promoted or when requester 0 is idle
  always_comb begin
    w_gnt1 = REQ1_V && !RST && ((state_q == STARV) || !REQ0_V);
    w_gnt0 = REQ0_V && !RST && !w_gnt1;
  end

  assign REQ0_R = w_gnt0;
  assign REQ1_R = w_gnt1;

  // Denial counting and promotion/demotion of requester 1
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (w_gnt1) begin
      // A requester-1 transfer ends any starvation episode
      cnt_d   = '0;
      state_d = NORM;
    end else begin
      if (REQ1_V) begin
        cnt_d = sat_inc(cnt_q);
      end
      // Promote on the same edge the counter reaches the threshold so the
      // very next cycle is granted to requester 1
      if (cnt_d >= c_starve_max) begin
        state_d = STARV;
      end
    end
  end

  // Next write-port contents from whichever requester completed a transfer
  always_comb begin
    we_d  = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (w_gnt0) begin
      we_d  = (REQ0_A != '0);
      a3_d  = REQ0_A;
      wd3_d = REQ0_D;
    end else if (w_gnt1) begin
      we_d  = (REQ1_A != '0);
      a3_d  = REQ1_A;
      wd3_d = REQ1_D;
    end
  end

  // State, counter and write-port registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= NORM;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

  assign WE  = we_q;
  assign A3  = a3_q;
  assign WD3 = wd3_q;

`ifdef RF_WB_ARBITER_FWD_EN
  // Pending write matches a read port; register 0 never forwards
  assign FWD1_HIT = we_q && (a3_q == RA1) && (a3_q != '0);
  assign FWD2_HIT = we_q && (a3_q == RA2) && (a3_q != '0);
  assign FWD_D    = wd3_q;
`else
  // Read addresses are deliberately unused in this build
  logic w_unused_ra;
  assign w_unused_ra = ^{RA1, RA2};
  assign FWD1_HIT    = 1'b0;
  assign FWD2_HIT    = 1'b0;
  assign FWD_D       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Brief    : Directed self-checking bench for rf_wb_arbiter (STARVE_MAX=4).
//             Inputs change 1ns after posedge; outputs sampled on negedge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        CLK;
  logic        RST;
  logic        REQ0_V, REQ1_V;
  logic [4:0]  REQ0_A, REQ1_A;
  logic [31:0] REQ0_D, REQ1_D;
  logic        REQ0_R, REQ1_R;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  RA1, RA2;
  logic        FWD1_HIT, FWD2_HIT;
  logic [31:0] FWD_D;

  int total;
  int bad;

  rf_wb_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_V(REQ0_V), .REQ0_A(REQ0_A), .REQ0_D(REQ0_D), .REQ0_R(REQ0_R),
    .REQ1_V(REQ1_V), .REQ1_A(REQ1_A), .REQ1_D(REQ1_D), .REQ1_R(REQ1_R),
    .WE(WE), .A3(A3), .WD3(WD3),
    .RA1(RA1), .RA2(RA2),
    .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT), .FWD_D(FWD_D)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  bit          exp1;
  bit          prev1;
  logic [31:0] last_d;
  logic [4:0]  last_a;
  logic        exp_hit1;
  logic [31:0] exp_fwd;

  initial begin
    total = 0;
    bad   = 0;
    RST = 1'b1;
    REQ0_V = 1'b1; REQ0_A = 5'd1; REQ0_D = 32'h1;
    REQ1_V = 1'b1; REQ1_A = 5'd2; REQ1_D = 32'h2;
    RA1 = 5'd0; RA2 = 5'd0;

    // Reset: no grant while RST, outputs cleared
    samp();
    chk("rst_r0", REQ0_R, 0);
    chk("rst_r1", REQ1_R, 0);
    chk("rst_we", WE, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_fwd1", FWD1_HIT, 0);
    chk("rst_fwd2", FWD2_HIT, 0);
    chk("rst_fwdd", FWD_D, 0);

    // Single request
    step();
    RST = 1'b0; REQ1_V = 1'b0;
    REQ0_V = 1'b1; REQ0_A = 5'd5; REQ0_D = 32'hDEADBEEF;
    samp();
    chk("single_r0", REQ0_R, 1);
    chk("single_r1", REQ1_R, 0);
    step();
    REQ0_V = 1'b0;
    samp();
    chk("single_we", WE, 1);
    chk("single_a3", A3, 5);
    chk("single_wd3", WD3, 32'hDEADBEEF);
    chk("idle_r0", REQ0_R, 0);
    step();
    samp();
    chk("idle_we", WE, 0);

    // Destination 0 accepted but not written
    step();
    REQ1_V = 1'b1; REQ1_A = 5'd0; REQ1_D = 32'h1234;
    samp();
    chk("dst0_r1", REQ1_R, 1);
    step();
    REQ1_V = 1'b0;
    samp();
    chk("dst0_we", WE, 0);

    // Starvation: both held, pattern 0,0,0,0,1 repeating
    step();
    REQ0_V = 1'b1; REQ0_A = 5'd2; REQ0_D = 32'h100;
    REQ1_V = 1'b1; REQ1_A = 5'd3; REQ1_D = 32'hB0;
    prev1 = 1'b0; last_d = 32'h0; last_a = 5'd0;
    for (int i = 0; i < 10; i++) begin
      samp();
      exp1 = ((i % 5) == 4);
      chk($sformatf("starv_r0_%0d", i), REQ0_R, {31'd0, ~exp1});
      chk($sformatf("starv_r1_%0d", i), REQ1_R, {31'd0, exp1});
      if (i > 0) begin
        chk($sformatf("starv_we_%0d", i), WE, 1);
        chk($sformatf("starv_a3_%0d", i), A3, {27'd0, last_a});
        chk($sformatf("starv_wd3_%0d", i), WD3, last_d);
      end
      last_a = exp1 ? 5'd3 : 5'd2;
      last_d = exp1 ? REQ1_D : REQ0_D;
      prev1 = exp1;
      step();
      if (!exp1) REQ0_D = REQ0_D + 32'h1;
    end
    REQ0_V = 1'b0; REQ1_V = 1'b0;
    samp();
    chk("starv_last_we", WE, 1);
    chk("starv_last_a3", A3, 3);
    chk("starv_last_wd3", WD3, 32'hB0);

    // STARV with requester 1 idle: requester 0 wins, state stays STARV
    step();
    REQ0_V = 1'b1;
    for (int i = 0; i < 7; i++) begin
      REQ1_V = (i != 4);
      samp();
      exp1 = (i == 5);
      chk($sformatf("hold_r0_%0d", i), REQ0_R, {31'd0, ~exp1});
      chk($sformatf("hold_r1_%0d", i), REQ1_R, {31'd0, exp1});
      step();
    end
    REQ0_V = 1'b0; REQ1_V = 1'b0;
    step();
    step();

    // Same destination from both, then back-to-back requester-1 writes
    REQ0_V = 1'b1; REQ0_A = 5'd10; REQ0_D = 32'h111;
    REQ1_V = 1'b1; REQ1_A = 5'd10; REQ1_D = 32'h222;
    samp();
    chk("same_r0", REQ0_R, 1);
    chk("same_r1", REQ1_R, 0);
    step();
    REQ0_V = 1'b0;
    samp();
    chk("same_we0", WE, 1);
    chk("same_a30", A3, 10);
    chk("same_wd30", WD3, 32'h111);
    chk("same_r1b", REQ1_R, 1);
    step();
    REQ1_A = 5'd11; REQ1_D = 32'h333;
    samp();
    chk("b2b_we1", WE, 1);
    chk("b2b_a31", A3, 10);
    chk("b2b_wd31", WD3, 32'h222);
    step();
    REQ1_A = 5'd12; REQ1_D = 32'h444;
    samp();
    chk("b2b_we2", WE, 1);
    chk("b2b_a32", A3, 11);
    chk("b2b_wd32", WD3, 32'h333);
    step();
    REQ1_V = 1'b0;
    samp();
    chk("b2b_we3", WE, 1);
    chk("b2b_a33", A3, 12);
    chk("b2b_wd33", WD3, 32'h444);
    step();
    samp();
    chk("b2b_idle_we", WE, 0);

    // Reset mid-stream with a non-zero denial count
    step();
    REQ0_V = 1'b1; REQ0_A = 5'd7; REQ0_D = 32'h77;
    REQ1_V = 1'b1; REQ1_A = 5'd1; REQ1_D = 32'h11;
    samp();
    chk("mid_r0a", REQ0_R, 1);
    step();
    samp();
    chk("mid_r0b", REQ0_R, 1);
    step();
    RST = 1'b1;
    samp();
    chk("mid_rst_r0", REQ0_R, 0);
    chk("mid_rst_r1", REQ1_R, 0);
    step();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      samp();
      if (i == 0) begin
        chk("mid_we", WE, 0);
        chk("mid_a3", A3, 0);
        chk("mid_wd3", WD3, 0);
      end
      exp1 = (i == 4);
      chk($sformatf("mid_cnt_r1_%0d", i), REQ1_R, {31'd0, exp1});
      step();
    end
    REQ0_V = 1'b0; REQ1_V = 1'b0;
    step();

    // Forwarding of the pending write
    REQ1_V = 1'b1; REQ1_A = 5'd9; REQ1_D = 32'h55;
    samp();
    chk("fwd_r1", REQ1_R, 1);
    step();
    REQ1_V = 1'b0; RA1 = 5'd9; RA2 = 5'd3;
`ifdef RF_WB_ARBITER_FWD_EN
    exp_hit1 = 1'b1; exp_fwd = 32'h55;
`else
    exp_hit1 = 1'b0; exp_fwd = 32'h0;
`endif
    samp();
    chk("fwd_we", WE, 1);
    chk("fwd_a3", A3, 9);
    chk("fwd_hit1", FWD1_HIT, {31'd0, exp_hit1});
    chk("fwd_hit2", FWD2_HIT, 0);
    chk("fwd_data", FWD_D, exp_fwd);
    step();
    samp();
    chk("fwd_idle_hit1", FWD1_HIT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_MAX, default 4, the number of consecutive lost arbitrations after which requester 1 is granted.
REQ-002 CLK  input  1  the single clock; all state updates on posedge CLK.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 REQ0_V / REQ0_A / REQ0_D  input  1/5/32  load-unit writeback: valid, destination register, data.
REQ-005 REQ0_R  output  1  load-unit ready; a transfer occurs when REQ0_V and REQ0_R are both 1 in the same cycle.
REQ-006 REQ1_V / REQ1_A / REQ1_D / REQ1_R  in/in/in/out  1/5/32/1  ALU writeback; same handshake as requester 0.
REQ-007 WE / A3 / WD3  output  1/5/32  registered register-file write port.
REQ-008 RA1 / RA2  input  5 each  register-file read addresses, used for forwarding.
REQ-009 FWD1_HIT / FWD2_HIT  output  1 each  the pending write matches RA1 / RA2.
REQ-010 FWD_D  output  32  the pending write data.

Function
REQ-011 The arbiter SHALL hold a state, NORM or STARV.
- NORM: requester 0 has priority.
- STARV: requester 1 has priority.
REQ-012 In any cycle, at most one of REQ0_R and REQ1_R SHALL be 1. The grant is combinational from REQx_V and the state.
REQ-013 REQx_R SHALL be 0 while REQx_V is 0 and while RST is 1.
REQ-014 A requester SHALL hold its V, A and D stable until its transfer completes; the block does not sample unhandshaken data.
REQ-015 Granted data SHALL reach WE/A3/WD3 exactly one cycle after the transfer (latency 1). With no transfer, WE SHALL be 0 the next cycle.
REQ-016 A transfer with destination 0 SHALL be accepted, with its ready asserted, but SHALL produce WE=0.
REQ-017 A 3-bit denial counter SHALL increment each cycle that REQ1_V=1 and REQ1 is not granted, and SHALL clear on any REQ1 transfer.
REQ-018 Entering STARV: when the denial counter reaches STARVE_MAX, the state SHALL become STARV on the next edge.
REQ-019 Leaving STARV: on the REQ1 transfer, the state SHALL return to NORM and the counter SHALL clear.
REQ-020 In STARV with REQ1_V=0, requester 0 SHALL be granted and the state SHALL stay STARV.
REQ-021 If both requesters target the same register in the same cycle, only the winner SHALL write. The loser writes in a later cycle; write-after-write ordering belongs to the issuing pipeline.
REQ-022 Back-to-back transfers SHALL sustain one write per cycle.

Reset
REQ-023 While RST=1 at posedge CLK:
- WE=0, A3=0, WD3=0;
- counter=0, state=NORM;
- any pending write is discarded and no grant is given.
REQ-024 FWD1_HIT and FWD2_HIT SHALL be 0 out of reset, and FWD_D SHALL be 0.

Configuration
REQ-025 Forwarding SHALL be controlled by the macro RF_WB_ARBITER_FWD_EN.
REQ-026 With RF_WB_ARBITER_FWD_EN defined:
- FWDn_HIT = WE & (A3 == RAn) & (A3 != 0), combinational;
- FWD_D = WD3.
REQ-027 Without RF_WB_ARBITER_FWD_EN: RA1/RA2 are ignored, FWD1_HIT=FWD2_HIT=0 and FWD_D=0 constantly; the ports remain present.

Structure
REQ-028 A shared package SHALL hold:
- constants REG_AW=5 and XLEN=32;
- the state encoding NORM=0, STARV=1.
REQ-029 The block SHALL be one module, with no sub-modules. The forwarding compare is inline and guarded by the macro.

Verification
REQ-030 Single request: REQ0_V=1, A=5, D=0xDEADBEEF -> REQ0_R=1 that cycle; next cycle WE=1, A3=5, WD3=0xDEADBEEF.
REQ-031 Destination 0: REQ1_V=1, A=0, D=0x1234 -> REQ1_R=1; next cycle WE=0.
REQ-032 Starvation: REQ0_V=1 and REQ1_V=1 held continuously, STARVE_MAX=4.
- REQ0 is granted 4 cycles.
- State becomes STARV and REQ1 is granted on the 5th cycle.
- State returns to NORM.
REQ-033 Reset mid-stream: assert RST in the cycle after a transfer to A=7 -> WE=0 on the next edge, no write to register 7, counter=0.
REQ-034 Forwarding, with RF_WB_ARBITER_FWD_EN defined: WE=1, A3=9, WD3=0x55, RA1=9, RA2=3 -> FWD1_HIT=1, FWD2_HIT=0, FWD_D=0x55.
REQ-035 Forwarding, without the macro: same stimulus as REQ-034 -> both hits 0.
